// File: rtl/vga_sync.sv
// 640x480@60 raster timing: pixel-rate divider, h/v scan counters, sync/blank decode.
// Define VGA_SYNC_OUTREG_EN to register hsync/vsync/video_on (1-clk lag, glitch-free pins).
module vga_sync #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pixel_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       refresh_tick
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
    localparam logic [9:0] HS_BEG = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    if (CLK_DIV < 2 || H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_param_check
        $error("vga_sync: CLK_DIV must be >= 2 and H/V totals must fit 10 bits");
    end

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             hsync_d;
    logic             vsync_d;
    logic             video_on_d;

    assign pixel_tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            div_cnt <= pixel_tick ? '0 : div_cnt + 1'b1;
            if (pixel_tick) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    assign pixel_x      = h_cnt;
    assign pixel_y      = v_cnt;
    // Fires on the first pixel of line V_DISPLAY: start of vertical blanking.
    assign refresh_tick = pixel_tick && (h_cnt == '0) && (v_cnt == V_VIS);

    assign hsync_d    = !((h_cnt >= HS_BEG) && (h_cnt <= HS_END));
    assign vsync_d    = !((v_cnt >= VS_BEG) && (v_cnt <= VS_END));
    assign video_on_d = (h_cnt < H_VIS) && (v_cnt < V_VIS);

`ifdef VGA_SYNC_OUTREG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b0;
        end else begin
            hsync    <= hsync_d;
            vsync    <= vsync_d;
            video_on <= video_on_d;
        end
    end
`else
    assign hsync    = hsync_d;
    assign vsync    = vsync_d;
    assign video_on = video_on_d;
`endif

endmodule

// File: tb/tb_vga_sync.sv
// Scoreboard bench for vga_sync on a shrunken raster; the reference derives every
// output from the clock count since reset using plain div/mod arithmetic.
module tb_vga_sync;
    localparam int CD = 3;
    localparam int HD = 8, HF = 2, HS = 3, HB = 2;
    localparam int VD = 6, VF = 2, VS = 2, VB = 2;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FRAME = HT * VT * CD;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pixel_tick, hsync, vsync, video_on, refresh_tick;
    logic [9:0] pixel_x, pixel_y;

    always #5 clk = ~clk;

    vga_sync #(
        .CLK_DIV(CD), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .hsync(hsync),
        .vsync(vsync), .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .refresh_tick(refresh_tick)
    );

    typedef struct packed {
        logic       rst;
        logic       tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       rt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
        end
    endtask

    // Reference: t clocks after the reset edge, pixel n = t/CD, position from n.
    function automatic exp_t ref_at(input int t);
        exp_t e;
        int d, n, h, v;
        d = t % CD;
        n = t / CD;
        h = n % HT;
        v = (n / HT) % VT;
        e.rst  = 1'b0;
        e.tick = (d == CD - 1);
        e.x    = 10'(h);
        e.y    = 10'(v);
        e.hs   = !(h >= HD + HF && h < HD + HF + HS);
        e.vs   = !(v >= VD + VF && v < VD + VF + VS);
        e.von  = (h < HD) && (v < VD);
        e.rt   = e.tick && ((n % (HT * VT)) == VD * HT);
        return e;
    endfunction

    // Model: one expected entry per clock edge once the first reset has been seen.
    initial begin
        int   t;
        bit   live;
        exp_t e, old;
        logic phs, pvs, pvon;
        t = 0; live = 0; phs = 1'b1; pvs = 1'b1; pvon = 1'b0;
        forever begin
            @(posedge clk);
            if (reset) begin
                t = 0; live = 1;
                phs = 1'b1; pvs = 1'b1; pvon = 1'b0;
            end else if (live) begin
                old = ref_at(t);
                phs = old.hs; pvs = old.vs; pvon = old.von;
                t++;
            end
            if (live) begin
                e = ref_at(t);
                e.rst = reset;
`ifdef VGA_SYNC_OUTREG_EN
                e.hs = phs; e.vs = pvs; e.von = pvon;
`endif
                q.push_back(e);
            end
        end
    end

    // Monitor: compare on the falling edge, away from the active edge.
    initial begin
        exp_t e;
        int   gap;
        bit   seen;
        gap = 0; seen = 0;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("pixel_tick",   pixel_tick,   e.tick);
                chk("pixel_x",      pixel_x,      e.x);
                chk("pixel_y",      pixel_y,      e.y);
                chk("hsync",        hsync,        e.hs);
                chk("vsync",        vsync,        e.vs);
                chk("video_on",     video_on,     e.von);
                chk("refresh_tick", refresh_tick, e.rt);
                gap++;
                if (e.rst) seen = 0;
                if (refresh_tick === 1'b1) begin
                    if (seen) chk("refresh_spacing", gap, FRAME);
                    seen = 1;
                    gap  = 0;
                end
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bit found;
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        run(2 * FRAME + 7);

        // Abort mid-frame at a chosen pixel.
        found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(negedge clk);
            if (pixel_x == 10'd3 && pixel_y == 10'd2) found = 1;
        end
        chk("find_pixel_3_2", found, 1);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        run(FRAME + 11);

        for (int k = 0; k < 6; k++) begin
            run($urandom_range(1, 2 * FRAME));
            reset = 1'b1;
            run($urandom_range(1, 3));
            reset = 1'b0;
        end

        run(3 * FRAME);
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vga_sync.md
# vga_sync

Raster timing generator for the 640x480 @ 60 Hz display pipeline. Divides the system clock down to the pixel rate, runs the horizontal and vertical scan counters, and drives the monitor's hsync/vsync. It also produces the `pixel_x`/`pixel_y` coordinates, the `video_on` window and the once-per-frame `refresh_tick` consumed by the sprite, road and score generators.

## Interface
- `CLK_DIV`, 4: system clocks per pixel (100 MHz -> 25 MHz); must be >= 2.
- `H_DISPLAY`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, pixels.
- `H_SYNC`, 96: hsync pulse width, pixels.
- `H_BACK`, 48: horizontal back porch, pixels.
- `V_DISPLAY`, 480: visible lines.
- `V_FRONT`, 10: vertical front porch, lines.
- `V_SYNC`, 2: vsync pulse width, lines.
- `V_BACK`, 33: vertical back porch, lines.
- `clk`  in  1  system clock (100 MHz).
- `reset`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `pixel_tick`  out  1  one-clk pulse per pixel period.
- `hsync`  out  1  horizontal sync, active low.
- `vsync`  out  1  vertical sync, active low.
- `video_on`  out  1  high inside the visible 640x480 window.
- `pixel_x`  out  10  current horizontal count, 0..H_TOTAL-1.
- `pixel_y`  out  10  current vertical count, 0..V_TOTAL-1.
- `refresh_tick`  out  1  one-clk pulse per frame, at start of vertical blanking.

## Operation
- Derived totals:
  - H_TOTAL = sum of H_* = 800.
  - V_TOTAL = sum of V_* = 525.
  - Both must be <= 1024 (10-bit counters). Elaboration check fails otherwise.
- Divider `div_cnt`, 0..CLK_DIV-1:
  - Increments every clk and wraps to 0.
  - `pixel_tick` = (div_cnt == CLK_DIV-1).
- Horizontal counter `h_cnt`:
  - Advances only on clocks where `pixel_tick` is high.
  - Wraps H_TOTAL-1 -> 0.
- Vertical counter `v_cnt`:
  - Advances only when `pixel_tick` is high and h_cnt == H_TOTAL-1.
  - Wraps V_TOTAL-1 -> 0.
  - On the frame wrap edge, h_cnt and v_cnt both go to 0 on the same clock.
- Output decode:
  - `pixel_x` = h_cnt; `pixel_y` = v_cnt. Values >= 640 / >= 480 are passed through unclamped during blanking.
  - `video_on` = (h_cnt < H_DISPLAY) && (v_cnt < V_DISPLAY).
  - `hsync` low for h_cnt in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656, 751].
  - `vsync` low for v_cnt in [490, 491].
- `refresh_tick` = pixel_tick && h_cnt == 0 && v_cnt == V_DISPLAY (480).
  - Exactly one clk wide, once per frame.
  - Consumers may update positions for a full blanking interval before line 0 is redrawn.
- No FSM beyond the counters; all state lives in the three counters.

## Timing
- Reset: on the first clk edge with `reset` high, div_cnt = 0, h_cnt = 0, v_cnt = 0.
- Output values while in reset:
  - `pixel_x` = 0, `pixel_y` = 0, `pixel_tick` = 0, `refresh_tick` = 0.
  - `hsync` = 1, `vsync` = 1.
  - `video_on` = 1 (without the macro below).
- First `pixel_tick` comes CLK_DIV-1 clocks after the first edge with `reset` low; h_cnt becomes 1 on the following edge.
- Period checks:
  - Line period = H_TOTAL*CLK_DIV = 3200 clks.
  - Frame period = 1,680,000 clks.
  - `refresh_tick` spacing is exactly one frame period.
- Reset asserted mid-frame: all counters return to 0 on that edge. No `refresh_tick` is emitted for the aborted frame. Timing restarts as after power-up.
- Outputs are combinational decodes of registered counters; no added latency (default build).

## Configuration
- `VGA_SYNC_OUTREG_EN` defined:
  - `hsync`, `vsync` and `video_on` are registered, updated on the clk after the counter change. This gives glitch-free pins and a 1-clk lag behind `pixel_x`/`pixel_y`; the lag is inside the pixel period because CLK_DIV >= 2.
  - Reset values: `hsync` = 1, `vsync` = 1, `video_on` = 0.
  - `pixel_x`, `pixel_y`, `pixel_tick` and `refresh_tick` are unchanged.
- `VGA_SYNC_OUTREG_EN` undefined: all outputs are combinational decodes as in Operation.

## Test plan
- Release reset, count clks -> first `pixel_tick` 3 clks after release; `pixel_tick` period 4 clks thereafter.
- Run one full line -> `hsync` low for exactly 96*4 = 384 clks, falling edge at h_cnt = 656; `pixel_x` wraps 799 -> 0 while `pixel_y` increments by 1.
- Run two frames -> `vsync` low for exactly 2 lines (6400 clks) starting at v_cnt = 490; `refresh_tick` pulses once per frame, 1,680,000 clks apart, 1 clk wide, with pixel_x = 0 and pixel_y = 480.
- Sample `video_on` -> high at (0,0), (639,479); low at (640,0), (0,480), (799,524).
- Assert `reset` for 1 clk at pixel (300,200) -> next edge pixel_x = 0, pixel_y = 0, `hsync` = `vsync` = 1; no `refresh_tick` until 480 lines later.
- With `VGA_SYNC_OUTREG_EN` defined -> `hsync` falls 1 clk after h_cnt reaches 656; `video_on` = 0 during reset.
